// File: rtl/lighthouse_pkg.sv
// Shared defaults, sweep word field widths and bit encodings for the lighthouse arbiter.
package lighthouse_pkg;

    localparam int NUM_SENSORS_DEF = 4;
    localparam int ANGLE_BITS_DEF  = 20;
    localparam int ID_BITS_DEF     = 4;
    localparam int DROP_BITS_DEF   = 16;
    localparam int TS_BITS_DEF     = 32;

    // A sweep word is sensor id, angle, lighthouse bit and axis bit
    localparam int LH_BITS   = 1;
    localparam int AXIS_BITS = 1;

    typedef enum logic {
        LH_B = 1'b0,
        LH_C = 1'b1
    } lh_e;

    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } axis_e;

endpackage

// File: rtl/lighthouse_rr_pick.sv
// Combinational round-robin picker: first pending index after rr, wrapping.
module lighthouse_rr_pick #(
    parameter int NUM_SENSORS = 4,
    parameter int ID_BITS     = 4
) (
    input  logic [NUM_SENSORS-1:0] pending,
    input  logic [ID_BITS-1:0]     rr,
    output logic                   any,
    output logic [ID_BITS-1:0]     grant
);

    always_comb begin
        int idx;
        idx   = 0;
        any   = 1'b0;
        grant = '0;
        // Scan farthest-first so the nearest candidate after rr wins last
        for (int k = NUM_SENSORS; k >= 1; k--) begin
            idx = (int'(rr) + k) % NUM_SENSORS;
            if (pending[idx]) begin
                any   = 1'b1;
                grant = ID_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/lighthouse_arbiter.sv
// Round-robin serialiser of per-sensor sweep results onto one valid/ready stream.
// Optional LIGHTHOUSE_ARB_TIMESTAMP_EN adds a capture timestamp to every word.
module lighthouse_arbiter
    import lighthouse_pkg::*;
#(
    parameter int NUM_SENSORS = NUM_SENSORS_DEF,
    parameter int ANGLE_BITS  = ANGLE_BITS_DEF,
    parameter int ID_BITS     = ID_BITS_DEF,
    parameter int DROP_BITS   = DROP_BITS_DEF
`ifdef LIGHTHOUSE_ARB_TIMESTAMP_EN
    ,
    parameter int TS_BITS     = TS_BITS_DEF
`endif
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_SENSORS-1:0]           in_strobe,
    input  logic [NUM_SENSORS*ANGLE_BITS-1:0] in_angle,
    input  logic [NUM_SENSORS-1:0]           in_lighthouse,
    input  logic [NUM_SENSORS-1:0]           in_axis,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [ID_BITS-1:0]               out_sensor,
    output logic [ANGLE_BITS-1:0]            out_angle,
    output logic                             out_lighthouse,
    output logic                             out_axis,
`ifdef LIGHTHOUSE_ARB_TIMESTAMP_EN
    output logic [TS_BITS-1:0]               out_timestamp,
`endif
    output logic [DROP_BITS-1:0]             drop_count,
    output logic [NUM_SENSORS-1:0]           pending
);

    logic [ANGLE_BITS-1:0]  slot_angle [NUM_SENSORS];
    logic [NUM_SENSORS-1:0] slot_lh;
    logic [NUM_SENSORS-1:0] slot_axis;
    logic [ID_BITS-1:0]     rr;
    logic [ID_BITS-1:0]     grant;
    logic                   any;
    logic                   load;
    logic                   fire;
    logic [NUM_SENSORS-1:0] hit;
    logic [NUM_SENSORS-1:0] drop;
    logic [DROP_BITS:0]     drop_sum;
    logic [DROP_BITS-1:0]   drop_next;
    logic [ANGLE_BITS-1:0]  sel_angle;
    logic                   sel_lh;
    logic                   sel_axis;
`ifdef LIGHTHOUSE_ARB_TIMESTAMP_EN
    logic [TS_BITS-1:0]     ts;
    logic [TS_BITS-1:0]     slot_ts [NUM_SENSORS];
    logic [TS_BITS-1:0]     sel_ts;
`endif

    lighthouse_rr_pick #(
        .NUM_SENSORS (NUM_SENSORS),
        .ID_BITS     (ID_BITS)
    ) u_pick (
        .pending (pending),
        .rr      (rr),
        .any     (any),
        .grant   (grant)
    );

    assign load = !out_valid || out_ready;
    assign fire = load && any;

    always_comb begin
        hit       = '0;
        drop      = '0;
        sel_angle = '0;
        sel_lh    = 1'b0;
        sel_axis  = 1'b0;
`ifdef LIGHTHOUSE_ARB_TIMESTAMP_EN
        sel_ts    = '0;
`endif
        drop_sum  = {1'b0, drop_count};
        for (int i = 0; i < NUM_SENSORS; i++) begin
            hit[i]  = fire && (grant == ID_BITS'(i));
            // A strobe onto the slot being granted is a refill, not a loss
            drop[i] = in_strobe[i] && pending[i] && !hit[i];
            if (grant == ID_BITS'(i)) begin
                sel_angle = slot_angle[i];
                sel_lh    = slot_lh[i];
                sel_axis  = slot_axis[i];
`ifdef LIGHTHOUSE_ARB_TIMESTAMP_EN
                sel_ts    = slot_ts[i];
`endif
            end
            drop_sum = drop_sum + {{DROP_BITS{1'b0}}, drop[i]};
        end
    end

    assign drop_next = drop_sum[DROP_BITS] ? '1 : drop_sum[DROP_BITS-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                slot_angle[i] <= '0;
            end
            slot_lh        <= '0;
            slot_axis      <= '0;
            pending        <= '0;
            rr             <= ID_BITS'(NUM_SENSORS - 1);
            out_valid      <= 1'b0;
            out_sensor     <= '0;
            out_angle      <= '0;
            out_lighthouse <= 1'b0;
            out_axis       <= 1'b0;
            drop_count     <= '0;
        end else begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (in_strobe[i]) begin
                    slot_angle[i] <= in_angle[i*ANGLE_BITS +: ANGLE_BITS];
                    slot_lh[i]    <= in_lighthouse[i];
                    slot_axis[i]  <= in_axis[i];
                    pending[i]    <= 1'b1;
                end else if (hit[i]) begin
                    pending[i]    <= 1'b0;
                end
            end
            if (load) begin
                out_valid <= any;
                if (any) begin
                    out_sensor     <= grant;
                    out_angle      <= sel_angle;
                    out_lighthouse <= sel_lh;
                    out_axis       <= sel_axis;
                    rr             <= grant;
                end
            end
            drop_count <= drop_next;
        end
    end

`ifdef LIGHTHOUSE_ARB_TIMESTAMP_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            ts            <= '0;
            out_timestamp <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                slot_ts[i] <= '0;
            end
        end else begin
            ts <= ts + 1'b1;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (in_strobe[i]) begin
                    slot_ts[i] <= ts;
                end
            end
            if (fire) begin
                out_timestamp <= sel_ts;
            end
        end
    end
`endif

endmodule
